// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory, decode and redirect signals of the fetch sequencer
interface fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        inst_ready;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        halt;
   logic        redir_misalign;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_pc, inst_data, redir_misalign,
      input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redir_valid, redir_pc, halt
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_pc, inst_data, redir_misalign,
      output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redir_valid, redir_pc, halt
   );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer with credit-limited imem fetch, instruction FIFO and redirect flush
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic          clk,
   input logic          rst_n,
   fetch_ctrl_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc, resp_pc, redir_al;
   logic [CW-1:0] outst, outst_nxt, count;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic          redir, issue, resp, push, pop, misalign;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Outstanding plus buffered fetches never exceed DEPTH, so a response always has a FIFO slot
   assign bus.imem_req = (state == FETCH) & ~bus.halt & ~bus.redir_valid &
                         (({1'b0, outst} + {1'b0, count}) < (CW + 1)'(DEPTH));
   assign bus.imem_addr      = fetch_pc;
   assign bus.inst_valid     = (count != '0);
   assign bus.inst_pc        = mem_pc[rd_ptr];
   assign bus.inst_data      = mem_data[rd_ptr];
   assign bus.redir_misalign = misalign;

   // Handshake qualifiers; a redirect's stale count is simply the next outstanding count
   always_comb begin
      redir     = bus.redir_valid & (state != IDLE);
      redir_al  = {bus.redir_pc[31:2], 2'b00};
      issue     = bus.imem_req & bus.imem_gnt;
      resp      = bus.imem_rvalid & (outst != '0) & (state != IDLE);
      push      = resp & (state == FETCH) & ~redir;
      pop       = bus.inst_valid & bus.inst_ready;
      outst_nxt = outst + CW'(issue) - CW'(resp);
      state_nxt = (state == IDLE) ? FETCH :
                  (redir || state == DRAIN) ? ((outst_nxt == '0) ? FETCH : DRAIN) : state;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   // Fetch/response PCs, outstanding count and misalign pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         outst    <= '0;
         misalign <= 1'b0;
      end else begin
         outst    <= outst_nxt;
         misalign <= redir & (|bus.redir_pc[1:0]);
         if (redir) begin
            fetch_pc <= redir_al;
            resp_pc  <= redir_al;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (push) resp_pc <= resp_pc + 32'd4;
         end
      end
   end

   // Instruction FIFO; a redirect empties it regardless of a same-cycle pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]   <= '0;
            mem_data[i] <= '0;
         end
      end else if (redir) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_pc[wr_ptr]   <= resp_pc;
            mem_data[wr_ptr] <= bus.imem_rdata;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule
